fb_write_scheduler: RTL and testbench

- Owns the single framebuffer write port of the LED-matrix display (write_en/write_x/write_y/write_color).
- Arbitrates round-robin between two valid/ready requesters: the SPI command stream (cmd_*) and the on-chip pattern generator (pat_*).
- Throttles writes to one per WRITE_INTERVAL cycles.
- Executes a full-frame fill command as an internal raster sweep.

---
 rtl/fb_pkg.sv | 26 ++
 rtl/fb_write_scheduler_if.sv | 39 +++
 rtl/fb_rr_arb2.sv | 32 +++
 rtl/fb_write_scheduler.sv | 138 +++++++++++++
 tb/tb_fb_write_scheduler.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared types and defaults for the framebuffer write scheduler.
package fb_pkg;

    localparam int FB_COORD_W = 6;
    localparam int FB_COLOR_W = 12;
    localparam int FB_DIM     = 64;

    typedef enum logic [1:0] {
        OP_PIXEL = 2'b00,
        OP_FILL  = 2'b01,
        OP_RSVD2 = 2'b10,
        OP_RSVD3 = 2'b11
    } cmd_op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic [FB_COORD_W-1:0] x;
        logic [FB_COORD_W-1:0] y;
        logic [FB_COLOR_W-1:0] color;
    } fb_write_t;

endpackage

// File: rtl/fb_write_scheduler_if.sv
// fb_write_scheduler_if: requester handshakes and framebuffer write port.
// master = requester/consumer side, slave = the scheduler.
interface fb_write_scheduler_if #(
    parameter int COORD_W = 6,
    parameter int COLOR_W = 12
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [COORD_W-1:0] cmd_x;
    logic [COORD_W-1:0] cmd_y;
    logic [COLOR_W-1:0] cmd_color;

    logic               pat_valid;
    logic               pat_ready;
    logic [COORD_W-1:0] pat_x;
    logic [COORD_W-1:0] pat_y;
    logic [COLOR_W-1:0] pat_color;

    logic               write_en;
    logic [COORD_W-1:0] write_x;
    logic [COORD_W-1:0] write_y;
    logic [COLOR_W-1:0] write_color;
    logic               busy;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color,
        output pat_valid, pat_x, pat_y, pat_color,
        input  cmd_ready, pat_ready,
        input  write_en, write_x, write_y, write_color, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color,
        input  pat_valid, pat_x, pat_y, pat_color,
        output cmd_ready, pat_ready,
        output write_en, write_x, write_y, write_color, busy
    );
endinterface

// File: rtl/fb_rr_arb2.sv
// fb_rr_arb2: two-requester round-robin arbiter. req[1]=cmd, req[0]=pat.
// Grant is combinational and implies the matching req, so any grant bit
// is a completed handshake.
module fb_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant
);
    // 1 when requester 1 won the last handshake; reset favours requester 1
    logic last_hi;

    // On contention, grant whoever did not win last time
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req == 2'b11)
                grant = last_hi ? 2'b01 : 2'b10;
            else
                grant = req;
        end
    end

    // Remember the winner only when a handshake actually happens
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_hi <= 1'b0;
        else if (|grant)
            last_hi <= grant[1];
    end
endmodule

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: sole owner of the framebuffer write port. Arbitrates
// cmd/pat round-robin, one write opportunity every WRITE_INTERVAL cycles.
// Build option: define FB_FILL_EN to build the full-frame fill sweep;
// otherwise fill is treated as a reserved op and busy is tied low.
module fb_write_scheduler
    import fb_pkg::*;
#(
    parameter int WRITE_INTERVAL = 16,
    parameter int COORD_W        = FB_COORD_W,
    parameter int COLOR_W        = FB_COLOR_W
) (
    input logic                 clk_in,
    input logic                 resetn,
    fb_write_scheduler_if.slave bus
);
    localparam int CNT_W = $clog2(WRITE_INTERVAL);

    logic [CNT_W-1:0]   cnt;
    logic               tick;
    logic               idle;
    logic [1:0]         grant;
    logic               wr_fire;
    logic               fill_tick;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic [COLOR_W-1:0] pix_color;

    // Free-running write-opportunity counter; count 0 is the tick
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn)
            cnt <= '0;
        else if (cnt == CNT_W'(WRITE_INTERVAL - 1))
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == '0);

    fb_rr_arb2 u_arb (
        .clk    (clk_in),
        .rst_n  (resetn),
        .req    ({bus.cmd_valid, bus.pat_valid}),
        .enable (tick && idle),
        .grant  (grant)
    );

    assign bus.cmd_ready = grant[1];
    assign bus.pat_ready = grant[0];

`ifdef FB_FILL_EN
    localparam logic [0:0] ST_IDLE = 1'(S_IDLE);
    localparam logic [0:0] ST_FILL = 1'(S_FILL);

    logic [0:0]         state;
    logic [COORD_W-1:0] fill_x;
    logic [COORD_W-1:0] fill_y;
    logic [COLOR_W-1:0] fill_color;
    logic               fill_accept;

    assign idle        = (state == ST_IDLE);
    assign fill_tick   = !idle && tick;
    assign fill_accept = grant[1] && (cmd_op_t'(bus.cmd_op) == OP_FILL);

    // Fill sweep: raster walk x-fastest, one pixel per tick, busy trails
    // the state by one cycle so it covers the last write strobe
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            fill_x     <= '0;
            fill_y     <= '0;
            fill_color <= '0;
            bus.busy   <= 1'b0;
        end else begin
            bus.busy <= !idle;
            if (fill_accept) begin
                state      <= ST_FILL;
                fill_x     <= '0;
                fill_y     <= '0;
                fill_color <= bus.cmd_color;
                bus.busy   <= 1'b1;
            end else if (fill_tick) begin
                fill_x <= fill_x + 1'b1;
                if (&fill_x) begin
                    fill_y <= fill_y + 1'b1;
                    if (&fill_y)
                        state <= ST_IDLE;
                end
            end
        end
    end
`else
    assign idle      = 1'b1;
    assign fill_tick = 1'b0;
    assign bus.busy  = 1'b0;
`endif

    // Select the payload for this tick: fill sweep, pattern, or command
    always_comb begin
        pix_x     = bus.cmd_x;
        pix_y     = bus.cmd_y;
        pix_color = bus.cmd_color;
        if (grant[0]) begin
            pix_x     = bus.pat_x;
            pix_y     = bus.pat_y;
            pix_color = bus.pat_color;
        end
`ifdef FB_FILL_EN
        if (!idle) begin
            pix_x     = fill_x;
            pix_y     = fill_y;
            pix_color = fill_color;
        end
`endif
    end

    // Reserved ops (and fill itself) are accepted without a write
    assign wr_fire = grant[0]
                   | (grant[1] && (cmd_op_t'(bus.cmd_op) == OP_PIXEL))
                   | fill_tick;

    // Write port: one-cycle strobe, address/data hold between writes
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            bus.write_en    <= 1'b0;
            bus.write_x     <= '0;
            bus.write_y     <= '0;
            bus.write_color <= '0;
        end else begin
            bus.write_en <= wr_fire;
            if (wr_fire) begin
                bus.write_x     <= pix_x;
                bus.write_y     <= pix_y;
                bus.write_color <= pix_color;
            end
        end
    end
endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: randomized scoreboard bench for fb_write_scheduler.
module tb_fb_write_scheduler;
    import fb_pkg::*;

    localparam int WI   = 16;
    localparam int CW   = 6;
    localparam int KW   = 12;
    localparam int NPIX = FB_DIM * FB_DIM;

    typedef struct {
        int        due;
        fb_write_t w;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    fb_write_scheduler_if #(.COORD_W(CW), .COLOR_W(KW)) bus ();

    fb_write_scheduler #(.WRITE_INTERVAL(WI), .COORD_W(CW), .COLOR_W(KW)) dut (
        .clk_in (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int k = 0;

    exp_t sb[$];
    exp_t mod_e;
    exp_t mon_e;

    // reference model state
    bit        m_last_cmd, m_fill, m_busy, eg_c, eg_p, fill_now, last_tick;
    int        m_p;
    logic [KW-1:0] m_fcol;
    bit        cmd_pend, pat_pend;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic [KW-1:0] c);
        mod_e.due     = cyc + 1;
        mod_e.w.x     = x;
        mod_e.w.y     = y;
        mod_e.w.color = c;
        sb.push_back(mod_e);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        k   <= resetn ? k + 1 : 0;
    end

    // Reference model: decides grants and expected writes from the rules
    always @(negedge clk) begin
        if (resetn) begin
            fill_now = m_fill;
            eg_c = 1'b0;
            eg_p = 1'b0;
            if (!fill_now && (k % WI == 0)) begin
                if (bus.cmd_valid && bus.pat_valid) begin
                    if (m_last_cmd) eg_p = 1'b1; else eg_c = 1'b1;
                end else if (bus.cmd_valid) eg_c = 1'b1;
                else if (bus.pat_valid) eg_p = 1'b1;
            end
            chk("cmd_ready", longint'(bus.cmd_ready), longint'(eg_c));
            chk("pat_ready", longint'(bus.pat_ready), longint'(eg_p));
            chk("busy", longint'(bus.busy), longint'(m_busy));
            if (eg_p) begin
                push_exp(bus.pat_x, bus.pat_y, bus.pat_color);
                m_last_cmd = 1'b0;
            end
            if (eg_c) begin
                m_last_cmd = 1'b1;
                if (bus.cmd_op == 2'b00)
                    push_exp(bus.cmd_x, bus.cmd_y, bus.cmd_color);
`ifdef FB_FILL_EN
                else if (bus.cmd_op == 2'b01) begin
                    m_fill = 1'b1;
                    m_p    = 0;
                    m_fcol = bus.cmd_color;
                end
`endif
            end
            last_tick = 1'b0;
            if (fill_now && (k % WI == 0)) begin
                push_exp(CW'(m_p % FB_DIM), CW'(m_p / FB_DIM), m_fcol);
                m_p++;
                if (m_p == NPIX) begin
                    m_fill    = 1'b0;
                    last_tick = 1'b1;
                end
            end
            m_busy = m_fill || last_tick;
        end
    end

    // Monitor: every write strobe must match the oldest due expectation
    always @(negedge clk) begin
        if (resetn) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                chk("write_en", longint'(bus.write_en), 1);
                chk("write_x", longint'(bus.write_x), longint'(mon_e.w.x));
                chk("write_y", longint'(bus.write_y), longint'(mon_e.w.y));
                chk("write_color", longint'(bus.write_color), longint'(mon_e.w.color));
            end else begin
                chk("unexpected write_en", longint'(bus.write_en), 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        cmd_pend = 1'b0;
        pat_pend = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.pat_valid = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        sb.delete();
        m_last_cmd = 1'b0;
        m_fill = 1'b0;
        m_busy = 1'b0;
        m_p = 0;
        eg_c = 1'b0;
        eg_p = 1'b0;
        clear_reqs();
        #1;
        chk("rst write_en", longint'(bus.write_en), 0);
        chk("rst busy", longint'(bus.busy), 0);
        chk("rst write_x", longint'(bus.write_x), 0);
        chk("rst write_y", longint'(bus.write_y), 0);
        chk("rst write_color", longint'(bus.write_color), 0);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic new_cmd(input bit allow_rsvd);
        int r;
        r = allow_rsvd ? int'($urandom_range(0, 5)) : 0;
        cmd_pend      = 1'b1;
        bus.cmd_x     = CW'($urandom_range(0, 63));
        bus.cmd_y     = CW'($urandom_range(0, 63));
        bus.cmd_color = KW'($urandom());
        if (r == 3)      bus.cmd_op = 2'b10;
        else if (r == 4) bus.cmd_op = 2'b11;
`ifndef FB_FILL_EN
        else if (r == 5) bus.cmd_op = 2'b01;
`endif
        else             bus.cmd_op = 2'b00;
    endtask

    task automatic new_pat();
        pat_pend      = 1'b1;
        bus.pat_x     = CW'($urandom_range(0, 63));
        bus.pat_y     = CW'($urandom_range(0, 63));
        bus.pat_color = KW'($urandom());
    endtask

    task automatic drive_random(input int n, input bit both_always, input bit allow_rsvd);
        for (int i = 0; i < n; i++) begin
            step();
            if (eg_c) cmd_pend = 1'b0;
            if (eg_p) pat_pend = 1'b0;
            if (cmd_pend && !both_always && $urandom_range(0, 19) == 0) cmd_pend = 1'b0;
            if (pat_pend && !both_always && $urandom_range(0, 19) == 0) pat_pend = 1'b0;
            if (!cmd_pend && (both_always || $urandom_range(0, 2) == 0)) new_cmd(allow_rsvd);
            if (!pat_pend && (both_always || $urandom_range(0, 2) == 0)) new_pat();
            bus.cmd_valid = cmd_pend;
            bus.pat_valid = pat_pend;
        end
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [KW-1:0] color);
        int t;
        bus.cmd_op    = op;
        bus.cmd_x     = CW'($urandom_range(0, 63));
        bus.cmd_y     = CW'($urandom_range(0, 63));
        bus.cmd_color = color;
        bus.cmd_valid = 1'b1;
        t = 0;
        do begin
            step();
            t++;
        end while (!eg_c && t < 40);
        chk("cmd accept timeout", longint'(eg_c), 1);
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        int t;
        bus.cmd_op = 2'b00;
        bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_color = '0;
        bus.pat_x = '0; bus.pat_y = '0; bus.pat_color = '0;
        clear_reqs();
        do_reset();

        // pattern requester held from reset release
        bus.pat_x = 6'd5; bus.pat_y = 6'd9; bus.pat_color = 12'hF00;
        bus.pat_valid = 1'b1;
        repeat (40) step();
        bus.pat_valid = 1'b0;

        // both requesters continuously valid: alternation
        drive_random(WI * 8, 1'b1, 1'b0);
        clear_reqs();

        // random traffic with reserved ops and early drops
        drive_random(WI * 120, 1'b0, 1'b1);
        clear_reqs();

        // reserved op explicitly
        issue_cmd(2'b10, 12'h123);
        repeat (40) step();
`ifndef FB_FILL_EN
        issue_cmd(2'b01, 12'h0F0);
        repeat (40) step();
`endif

        // valid raised 3 cycles before a tick and dropped 1 cycle before it
        t = 0;
        do begin step(); t++; end while ((k % WI) != WI - 3 && t < 40);
        chk("align timeout", longint'(k % WI), WI - 3);
        new_pat();
        bus.pat_valid = 1'b1;
        step();
        step();
        bus.pat_valid = 1'b0;
        pat_pend = 1'b0;
        repeat (3) step();
        drive_random(WI * 4, 1'b1, 1'b0);
        clear_reqs();

        // reset in the middle of a pixel write strobe
        new_pat();
        bus.pat_valid = 1'b1;
        t = 0;
        do begin step(); t++; end while (sb.size() == 0 && t < 40);
        chk("pre-reset write_en", longint'(bus.write_en), 1);
        do_reset();
        drive_random(WI * 6, 1'b0, 1'b0);
        clear_reqs();

`ifdef FB_FILL_EN
        // full-frame fill while the pattern requester waits
        issue_cmd(2'b01, 12'h0F0);
        bus.pat_x = 6'd33; bus.pat_y = 6'd44; bus.pat_color = 12'hABC;
        bus.pat_valid = 1'b1;
        t = 0;
        while (m_fill && t < NPIX * WI + 100) begin step(); t++; end
        chk("fill timeout", longint'(m_fill), 0);
        repeat (40) step();
        bus.pat_valid = 1'b0;

        // reset while fill pixel (10,3) is being written
        issue_cmd(2'b01, KW'($urandom()));
        t = 0;
        while (m_p != 3 * FB_DIM + 11 && t < 300 * WI) begin step(); t++; end
        chk("fill (10,3) write_en", longint'(bus.write_en), 1);
        chk("fill (10,3) write_x", longint'(bus.write_x), 10);
        chk("fill (10,3) write_y", longint'(bus.write_y), 3);
        do_reset();
        new_pat();
        bus.pat_valid = 1'b1;
        repeat (WI * 4) step();
        clear_reqs();
`endif

        repeat (WI + 4) step();
        chk("scoreboard drained", longint'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
